// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b computed LSB first, one bit per clock,
// with a start/busy/done handshake. Results are held on diff/borrow until the next done.
module serial_subtractor #(
    parameter int WIDTH = 2
) (
    input  logic             CLK100MHZ,
    input  logic             CPU_RESETN,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] part;
    logic             br;
    logic [CNT_W-1:0] cnt;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH:0]   part_ext;
    logic             last_bit;

    // Full-subtractor cell: returns {borrow_out, difference_bit}.
    function automatic logic [1:0] sub_bit(input logic ak, input logic bk, input logic bi);
        logic d;
        logic bo;
        d  = ak ^ bk ^ bi;
        bo = (~ak & bk) | (~(ak ^ bk) & bi);
        return {bo, d};
    endfunction

    always_comb begin
        {br_nxt, d_bit} = sub_bit(a_sr[0], b_sr[0], br);
        // New bit enters from the MSB side so bit 0 ends up in the LSB after WIDTH shifts.
        part_ext = {d_bit, part};
        last_bit = (cnt == LAST);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            part   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        part <= '0;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    part <= part_ext[WIDTH:1];
                    br   <= br_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    // Outputs update only on the edge that enters DONE.
                    if (last_bit) begin
                        diff   <= part_ext[WIDTH:1];
                        borrow <= br_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=2 and a WIDTH=8 instance run side by side and are
// compared every cycle against a transaction-level reference model.
module tb_serial_subtractor;

    logic       clk;
    logic       rst_n;
    logic       st2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2;
    logic       done2;
    logic [1:0] diff2;
    logic       brw2;
    logic       st8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8;
    logic       done8;
    logic [7:0] diff8;
    logic       brw8;

    serial_subtractor #(.WIDTH(2)) u2 (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .start     (st2),
        .a         (a2),
        .b         (b2),
        .busy      (busy2),
        .done      (done2),
        .diff      (diff2),
        .borrow    (brw2)
    );

    serial_subtractor #(.WIDTH(8)) u8 (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .start     (st8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .diff      (diff8),
        .borrow    (brw8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int n;

    // Reference model state, index 0 = WIDTH 2, index 1 = WIDTH 8.
    int          act[2];
    int          acc[2];
    logic [15:0] pa[2];
    logic [15:0] pb[2];
    logic [15:0] e_diff[2];
    logic        e_brw[2];
    logic        e_done[2];
    logic        accepted[2];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; acc[i] = 0; pa[i] = '0; pb[i] = '0;
            e_diff[i] = '0; e_brw[i] = 1'b0; e_done[i] = 1'b0; accepted[i] = 1'b0;
        end
    endtask

    // One operation: accepted at edge c, result visible after edge c+W, idle again after c+W+1.
    task automatic model_edge(input int i, input int w, input logic s,
                              input logic [15:0] av, input logic [15:0] bv);
        logic [15:0] m;
        m = (16'd1 << w) - 16'd1;
        accepted[i] = 1'b0;
        e_done[i]   = 1'b0;
        if (act[i] != 0) begin
            if (n == acc[i] + w) begin
                e_done[i] = 1'b1;
                e_diff[i] = (pa[i] - pb[i]) & m;
                e_brw[i]  = (pa[i] < pb[i]);
            end
            if (n == acc[i] + w + 1) act[i] = 0;
        end else if (s) begin
            act[i] = 1; acc[i] = n; pa[i] = av & m; pb[i] = bv & m; accepted[i] = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("busy2", 16'(busy2), 16'(act[0] != 0));
        chk("done2", 16'(done2), 16'(e_done[0]));
        chk("diff2", 16'(diff2), e_diff[0]);
        chk("borrow2", 16'(brw2), 16'(e_brw[0]));
        chk("busy8", 16'(busy8), 16'(act[1] != 0));
        chk("done8", 16'(done8), 16'(e_done[1]));
        chk("diff8", 16'(diff8), e_diff[1]);
        chk("borrow8", 16'(brw8), 16'(e_brw[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (rst_n) begin
            model_edge(0, 2, st2, 16'(a2), 16'(b2));
            model_edge(1, 8, st8, 16'(a8), 16'(b8));
        end
        #1;
        check_all();
    endtask

    // Directed single operation on one instance; waits (bounded) for done and checks constants.
    task automatic run_op(input int i, input logic [7:0] av, input logic [7:0] bv,
                          input logic [15:0] exp_d, input logic exp_b, input string tag);
        int w;
        int lat;
        logic seen;
        w = (i == 0) ? 2 : 8;
        if (i == 0) begin st2 = 1'b1; a2 = av[1:0]; b2 = bv[1:0]; end
        else begin st8 = 1'b1; a8 = av; b8 = bv; end
        tick();
        st2 = 1'b0; st8 = 1'b0;
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 30 && !seen; k++) begin
            tick();
            if ((i == 0) ? done2 : done8) begin
                seen = 1'b1;
                lat = k;
            end
        end
        chk({tag, "_seen"}, 16'(seen), 16'd1);
        chk({tag, "_lat"}, 16'(lat), 16'(w));
        chk({tag, "_diff"}, (i == 0) ? 16'(diff2) : 16'(diff8), exp_d);
        chk({tag, "_borrow"}, (i == 0) ? 16'(brw2) : 16'(brw8), 16'(exp_b));
        tick();
    endtask

    initial begin
        int pair;
        int results;
        int last_acc;
        int ndone;
        n_cmp = 0; n_fail = 0; n = 0;
        model_reset();
        rst_n = 1'b0;
        st2 = 1'b0; a2 = '0; b2 = '0;
        st8 = 1'b0; a8 = '0; b8 = '0;
        tick();
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Directed results from the lab sheet.
        run_op(0, 8'd3, 8'd1, 16'd2, 1'b0, "w2_3m1");
        run_op(0, 8'd1, 8'd2, 16'd3, 1'b1, "w2_1m2");
        run_op(0, 8'd0, 8'd0, 16'd0, 1'b0, "w2_0m0");
        run_op(1, 8'd0, 8'd255, 16'd1, 1'b1, "w8_0m255");
        run_op(1, 8'd255, 8'd0, 16'd255, 1'b0, "w8_255m0");
        run_op(1, 8'd77, 8'd77, 16'd0, 1'b0, "w8_eq");

        // Exhaustive WIDTH=2 with start held high; operands advance after each acceptance.
        pair = 0; results = 0; last_acc = -1;
        a2 = 2'd0; b2 = 2'd0; st2 = 1'b1;
        for (int k = 0; k < 200 && results < 16; k++) begin
            tick();
            if (done2) results++;
            if (accepted[0]) begin
                if (last_acc >= 0) chk("b2b_period", 16'(n - last_acc), 16'd4);
                last_acc = n;
                pair++;
                if (pair >= 16) st2 = 1'b0;
                a2 = 2'(pair >> 2);
                b2 = 2'(pair);
            end
        end
        st2 = 1'b0;
        chk("exh_count", 16'(results), 16'd16);
        tick(); tick();

        // Start requests during SHIFT and DONE are ignored.
        st2 = 1'b1; a2 = 2'd2; b2 = 2'd1;
        tick();
        a2 = 2'd0; b2 = 2'd3;
        ndone = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done2) ndone++;
        end
        st2 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (done2) ndone++;
        end
        chk("ign_ndone", 16'(ndone), 16'd1);
        chk("ign_diff", 16'(diff2), 16'd1);
        chk("ign_borrow", 16'(brw2), 16'd0);

        // Asynchronous reset in the middle of SHIFT.
        run_op(0, 8'd1, 8'd2, 16'd3, 1'b1, "pre_rst");
        st2 = 1'b1; a2 = 2'd3; b2 = 2'd0;
        st8 = 1'b1; a8 = 8'd1; b8 = 8'd200;
        tick();
        st2 = 1'b0; st8 = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_busy2", 16'(busy2), 16'd0);
        chk("rst_diff2", 16'(diff2), 16'd0);
        chk("rst_borrow2", 16'(brw2), 16'd0);
        chk("rst_busy8", 16'(busy8), 16'd0);
        #1 rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done2 || done8) ndone++;
        end
        chk("rst_nodone", 16'(ndone), 16'd0);
        run_op(0, 8'd3, 8'd2, 16'd1, 1'b0, "post_rst");

        // Randomized traffic on both instances, operands wiggling every cycle.
        for (int k = 0; k < 600; k++) begin
            st2 = 1'($urandom_range(0, 1));
            a2  = 2'($urandom);
            b2  = 2'($urandom);
            st8 = 1'($urandom_range(0, 1));
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
